// File: rtl/regfile_cmd_master_pkg.sv
// Shared widths and FSM state type for the register-file command master.
package rf_cmd_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ
    } state_t;

    // Burst line addresses wrap around the 16-line file.
    function automatic logic [ADDR_W-1:0] next_line(input logic [ADDR_W-1:0] line);
        return line + 1'b1;
    endfunction

endpackage

// File: rtl/regfile_cmd_master_if.sv
// Host-facing command, write-data and read-response channels of the command master.
interface regfile_cmd_master_if;
    import rf_cmd_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [LEN_W-1:0]  cmd_len;

    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              wr_done;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rsp_ready,
        input  cmd_ready, wr_ready, wr_done,
        input  rsp_valid, rsp_data, rsp_last
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rsp_ready,
        output cmd_ready, wr_ready, wr_done,
        output rsp_valid, rsp_data, rsp_last
    );

endinterface

// File: rtl/regfile_cmd_master_rsp_slot.sv
// One-entry valid/ready holding register for read responses (data + last flag).
module rf_rsp_slot
    import rf_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    input  logic              ready,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    // A load wins over a drain so a simultaneous pop and issue causes no bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            last  <= load_last;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_cmd_master.sv
// Burst command initiator for a 16x32 register file: streams writes in, streams reads out.
module regfile_cmd_master
    import rf_cmd_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    regfile_cmd_master_if.slave bus,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_write_line,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_read_en,
    output logic [ADDR_W-1:0] rf_read_line,
    input  logic [DATA_W-1:0] rf_data_out
);

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  count;
    logic              issue;
    logic              final_beat;

    // A read beat issues whenever the response slot is empty or being drained.
    assign issue        = (state == READ) && (!bus.rsp_valid || bus.rsp_ready);
    assign final_beat   = (count == '0);
    assign rf_read_en   = issue;
    assign rf_read_line = issue ? addr : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            addr          <= '0;
            count         <= '0;
            bus.cmd_ready <= 1'b0;
            bus.wr_ready  <= 1'b0;
            bus.wr_done   <= 1'b0;
            rf_write_en   <= 1'b0;
            rf_write_line <= '0;
            rf_data_in    <= '0;
        end else begin
            rf_write_en <= 1'b0;
            bus.wr_done <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready <= 1'b1;
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        addr          <= bus.cmd_addr;
                        count         <= bus.cmd_len;
                        bus.cmd_ready <= 1'b0;
                        if (bus.cmd_write) begin
                            state        <= WRITE;
                            bus.wr_ready <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (bus.wr_valid && bus.wr_ready) begin
                        rf_write_en   <= 1'b1;
                        rf_write_line <= addr;
                        rf_data_in    <= bus.wr_data;
                        addr          <= next_line(addr);
                        count         <= count - 1'b1;
                        // The final write lands together with wr_done and the return to idle.
                        if (final_beat) begin
                            bus.wr_ready  <= 1'b0;
                            bus.wr_done   <= 1'b1;
                            bus.cmd_ready <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr  <= next_line(addr);
                        count <= count - 1'b1;
                        if (final_beat) begin
                            bus.cmd_ready <= 1'b1;
                            state         <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    rf_rsp_slot u_rsp_slot (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (issue),
        .load_data (rf_data_out),
        .load_last (final_beat),
        .ready     (bus.rsp_ready),
        .valid     (bus.rsp_valid),
        .data      (bus.rsp_data),
        .last      (bus.rsp_last)
    );

endmodule

// File: tb/tb_regfile_cmd_master.sv
// Directed bench for regfile_cmd_master with a behavioural register file and write/response scoreboards.
module tb_regfile_cmd_master;
    import rf_cmd_pkg::*;

    typedef struct {
        logic [ADDR_W-1:0] line;
        logic [DATA_W-1:0] data;
        logic              last;
    } beat_t;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              preload = 1'b1;
    logic              rf_write_en;
    logic [ADDR_W-1:0] rf_write_line;
    logic [DATA_W-1:0] rf_data_in;
    logic              rf_read_en;
    logic [ADDR_W-1:0] rf_read_line;
    logic [DATA_W-1:0] rf_data_out;
    logic [DATA_W-1:0] rf_mem  [16];
    logic [DATA_W-1:0] exp_mem [16];

    beat_t             wr_q  [$];
    beat_t             rsp_q [$];
    beat_t             mon_beat;
    logic              held_valid = 1'b0;
    logic [DATA_W-1:0] held_data = '0;
    logic              held_last = 1'b0;
    logic              rd_done;
    int                checks = 0;
    int                errors = 0;

    always #5 clk = ~clk;

    regfile_cmd_master_if bus ();

    regfile_cmd_master dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .rf_write_en   (rf_write_en),
        .rf_write_line (rf_write_line),
        .rf_data_in    (rf_data_in),
        .rf_read_en    (rf_read_en),
        .rf_read_line  (rf_read_line),
        .rf_data_out   (rf_data_out)
    );

    function automatic logic [DATA_W-1:0] init_word(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    // Behavioural 16x32 register file: clocked write, combinational gated read.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 16; i++) rf_mem[i] <= init_word(i);
        end else if (rf_write_en) begin
            rf_mem[rf_write_line] <= rf_data_in;
        end
    end

    assign rf_data_out = rf_read_en ? rf_mem[rf_read_line] : '0;

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Scoreboard monitor: pops expected writes/responses as the DUT produces them.
    always @(negedge clk) begin
        if (!reset_n) begin
            held_valid = 1'b0;
        end else begin
            check_output("rf_excl", 32'(rf_write_en & rf_read_en), 32'd0);
            if (rf_write_en) begin
                check_output("wr_expected", 32'(wr_q.size() != 0), 32'd1);
                if (wr_q.size() != 0) begin
                    mon_beat = wr_q.pop_front();
                    check_output("wr_line", 32'(rf_write_line), 32'(mon_beat.line));
                    check_output("wr_data", rf_data_in, mon_beat.data);
                    check_output("wr_done", 32'(bus.wr_done), 32'(mon_beat.last));
                end
            end else begin
                check_output("wr_done_idle", 32'(bus.wr_done), 32'd0);
            end
            if (bus.rsp_valid && held_valid) begin
                check_output("rsp_hold_data", bus.rsp_data, held_data);
                check_output("rsp_hold_last", 32'(bus.rsp_last), 32'(held_last));
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                check_output("rsp_expected", 32'(rsp_q.size() != 0), 32'd1);
                if (rsp_q.size() != 0) begin
                    mon_beat = rsp_q.pop_front();
                    check_output("rsp_data", bus.rsp_data, mon_beat.data);
                    check_output("rsp_last", 32'(bus.rsp_last), 32'(mon_beat.last));
                end
            end
            held_valid = bus.rsp_valid && !bus.rsp_ready;
            held_data  = bus.rsp_data;
            held_last  = bus.rsp_last;
        end
    end

    task automatic apply_stimulus(input logic write, input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = write;
        bus.cmd_addr  = addr;
        bus.cmd_len   = len;
        @(negedge clk);
        while (!bus.cmd_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        check_output("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                               input int gap, input logic [DATA_W-1:0] base);
        int n;
        logic [ADDR_W-1:0] line;
        apply_stimulus(1'b1, addr, len);
        for (int i = 0; i <= int'(len); i++) begin
            if (i > 0) begin
                repeat (gap) begin
                    bus.wr_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            line          = addr + ADDR_W'(i);
            bus.wr_valid  = 1'b1;
            bus.wr_data   = base + 32'(i);
            exp_mem[line] = base + 32'(i);
            wr_q.push_back('{line: line, data: base + 32'(i), last: (i == int'(len))});
            n = 0;
            @(negedge clk);
            while (!bus.wr_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            check_output("wr_accept", 32'(bus.wr_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        bus.wr_valid = 1'b0;
        n = 0;
        while (wr_q.size() != 0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_output("wr_drain", 32'(wr_q.size()), 32'd0);
        check_output("wr_end_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_output("wr_end_wr_ready", 32'(bus.wr_ready), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic read_burst(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len, input int mode);
        logic [ADDR_W-1:0] line;
        for (int i = 0; i <= int'(len); i++) begin
            line = addr + ADDR_W'(i);
            rsp_q.push_back('{line: line, data: exp_mem[line], last: (i == int'(len))});
        end
        rd_done = 1'b0;
        fork
            begin
                int k = 0;
                while (!rd_done && k < 400) begin
                    bus.rsp_ready = (mode == 0) || (k % 3 == 0);
                    @(posedge clk);
                    #1;
                    k++;
                end
                bus.rsp_ready = 1'b1;
            end
            begin
                int n = 0;
                apply_stimulus(1'b0, addr, len);
                @(negedge clk);
                check_output("rd_issue_en", 32'(rf_read_en), 32'd1);
                check_output("rd_issue_line", 32'(rf_read_line), 32'(addr));
                check_output("rd_lat_not_yet", 32'(bus.rsp_valid), 32'd0);
                @(negedge clk);
                check_output("rd_lat_valid", 32'(bus.rsp_valid), 32'd1);
                if (mode == 0) begin
                    for (int i = 0; i < int'(len); i++) begin
                        @(negedge clk);
                        check_output("rd_stream", 32'(bus.rsp_valid), 32'd1);
                    end
                end
                #1;
                while (rsp_q.size() != 0 && n < 200) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                check_output("rsp_drain", 32'(rsp_q.size()), 32'd0);
                rd_done = 1'b1;
            end
        join
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.wr_valid  = 1'b0;
        bus.wr_data   = '0;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 16; i++) exp_mem[i] = init_word(i);
        repeat (2) @(posedge clk);
        #1;
        preload = 1'b0;

        // Reset state and first clock after release.
        @(negedge clk);
        check_output("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_output("rst_rf_write_en", 32'(rf_write_en), 32'd0);
        check_output("rst_rf_read_en", 32'(rf_read_en), 32'd0);
        check_output("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_output("rel_cmd_ready_pre", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        check_output("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_output("rel_wr_ready", 32'(bus.wr_ready), 32'd0);
        check_output("rel_rf_write_line", 32'(rf_write_line), 32'd0);
        check_output("rel_rf_read_line", 32'(rf_read_line), 32'd0);
        check_output("rel_rf_data_in", rf_data_in, 32'd0);
        check_output("rel_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;

        $display("[TB] write addr=3 len=2 back-to-back");
        write_burst(4'd3, 4'd2, 0, 32'h0000_00A0);
        $display("[TB] read addr=3 len=2 full throughput");
        read_burst(4'd3, 4'd2, 0);
        $display("[TB] read addr=14 len=3 with backpressure");
        read_burst(4'd14, 4'd3, 1);
        $display("[TB] write addr=15 len=1 with 3-cycle gap");
        write_burst(4'd15, 4'd1, 3, 32'h0000_00B0);
        read_burst(4'd15, 4'd1, 0);

        // Reset lands while the second write of a 4-beat burst is on the regfile port.
        $display("[TB] reset mid write burst");
        apply_stimulus(1'b1, 4'd8, 4'd3);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 32'h5A5A_0008;
        exp_mem[8]   = 32'h5A5A_0008;
        wr_q.push_back('{line: 4'd8, data: 32'h5A5A_0008, last: 1'b0});
        @(negedge clk);
        check_output("rst_burst_wr_ready", 32'(bus.wr_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.wr_data = 32'h5A5A_0009;
        @(posedge clk);
        #1;
        check_output("rst_burst_write_active", 32'(rf_write_en), 32'd1);
        #1;
        reset_n      = 1'b0;
        bus.wr_valid = 1'b0;
        #1;
        check_output("rst_async_write_en", 32'(rf_write_en), 32'd0);
        check_output("rst_async_wr_ready", 32'(bus.wr_ready), 32'd0);
        check_output("rst_async_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_output("rst_again_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_output("rst_again_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        read_burst(4'd8, 4'd3, 0);

        $display("[TB] read addr=1 len=15 wrapping");
        read_burst(4'd1, 4'd15, 0);

        repeat (2) @(posedge clk);
        check_output("final_wr_q", 32'(wr_q.size()), 32'd0);
        check_output("final_rsp_q", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
